// File: rtl/cpu_clken_pkg.sv
// rtl/cpu_clken_pkg.sv - shared speed/model encodings and level helper for cpu_clken
package cpu_clken_pkg;

  typedef logic [1:0] spd_t;

  typedef enum logic [1:0] {
    SPD_35 = 2'd0,
    SPD_7  = 2'd1,
    SPD_14 = 2'd2
  } spd_e;

  typedef enum logic {
    MODEL_48  = 1'b0,
    MODEL_128 = 1'b1
  } model_e;

  // Divider level (1-based) that clocks the CPU at a given turbo speed
  function automatic int lvl(input int base, input spd_t spd);
    return base - int'(spd);
  endfunction

endpackage

// File: rtl/cpu_clken_if.sv
// rtl/cpu_clken_if.sv - CPU bus, speed request and enable outputs of cpu_clken
interface cpu_clken_if
  import cpu_clken_pkg::*;
#(
  parameter int DIVW = 4
);
  spd_t            speed;
  logic            model;
  logic            pageCn;
  logic            vidCn;
  logic            mreq;
  logic            iorq;
  logic [15:0]     a;
  logic [DIVW-1:0] cep;
  logic [DIVW-1:0] cen;
  logic            cpuCep;
  logic            cpuCen;
  logic            contend;
  spd_t            spdAct;

  modport master (
    output speed, model, pageCn, vidCn, mreq, iorq, a,
    input  cep, cen, cpuCep, cpuCen, contend, spdAct
  );

  modport slave (
    input  speed, model, pageCn, vidCn, mreq, iorq, a,
    output cep, cen, cpuCep, cpuCen, contend, spdAct
  );
endinterface

// File: rtl/cpu_clken_ce_divider.sv
// rtl/cpu_clken_ce_divider.sv - free-running counter with registered p/n pulses per level
module ce_divider #(
  parameter int DIVW = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic [DIVW-1:0] cnt,
  output logic [DIVW-1:0] cep,
  output logic [DIVW-1:0] cen
);

  logic [DIVW-1:0] cepNext;
  logic [DIVW-1:0] cenNext;
  logic [DIVW-1:0] mask;

  // Level k+1 sees the low k+1 counter bits: n-phase at 0, p-phase at half period
  always_comb begin
    cepNext = '0;
    cenNext = '0;
    mask    = '0;
    for (int k = 0; k < DIVW; k++) begin
      mask       = (DIVW'(1) << (k + 1)) - DIVW'(1);
      cenNext[k] = ((cnt & mask) == '0);
      cepNext[k] = ((cnt & mask) == (DIVW'(1) << k));
    end
  end

  // Counter wraps naturally; pulses are registered so they trail cnt by one clock
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
      cep <= '0;
      cen <= '0;
    end else begin
      cnt <= cnt + DIVW'(1);
      cep <= cepNext;
      cen <= cenNext;
    end
  end

endmodule

// File: rtl/cpu_clken.sv
// rtl/cpu_clken.sv - clock enables, turbo speed switching and ULA contention for the CPU
module cpu_clken
  import cpu_clken_pkg::*;
#(
  parameter int DIVW = 4,
  parameter int BASE = 3,
  parameter int NSPD = 3
) (
  input  logic        clock,
  input  logic        reset,
  cpu_clken_if.slave  bus
);

  localparam spd_t SPD_MAX = spd_t'(NSPD - 1);

  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] cep;
  logic [DIVW-1:0] cen;
  logic [DIVW-1:0] lvlMask;
  spd_t            spdReq;
  spd_t            spdAct;
  logic            cpuHi;
  logic            ccd;
  logic            ioT;
  logic            mrT;
  logic            contendQ;
  logic            contend;
  logic            cacc;
  logic            selCep;
  logic            selCen;
  logic            cpuCep;
  logic            cpuCen;

  ce_divider #(.DIVW(DIVW)) u_div (
    .clock (clock),
    .reset (reset),
    .cnt   (cnt),
    .cep   (cep),
    .cen   (cen)
  );

  assign spdReq  = (int'(bus.speed) >= NSPD) ? SPD_MAX : bus.speed;
  assign lvlMask = DIVW'(1) << (lvl(BASE, spdAct) - 1);
  assign selCep  = |(cep & lvlMask);
  assign selCen  = |(cen & lvlMask);

  // Contention only exists at base speed, so a turbo speed masks it at once
  assign contend = contendQ & (spdAct == SPD_35);

  assign cacc = (!bus.mreq && bus.a[15:14] == 2'b01)
              || (bus.model == MODEL_128 && !bus.mreq && bus.a[15:14] == 2'b11 && bus.pageCn)
              || (!bus.iorq && !bus.a[0])
              || (!bus.iorq && bus.a[15:14] == 2'b01);

  // ccd lets the falling CPU edge through while a stretch is just starting
  assign cpuCep = selCep & ~contend;
  assign cpuCen = selCen & (~contend | ccd);

  // Speed latches only at cnt==0, contention state tracks the modelled CPU clock
  always_ff @(posedge clock) begin
    if (!reset) begin
      spdAct   <= SPD_35;
      cpuHi    <= 1'b1;
      ccd      <= 1'b1;
      ioT      <= 1'b1;
      mrT      <= 1'b1;
      contendQ <= 1'b0;
    end else begin
      if (cnt == '0) spdAct <= spdReq;
      if (cep[0]) ccd <= ~contend;
      if (cpuCep) begin
        ioT <= bus.iorq | bus.a[0];
        mrT <= bus.mreq;
      end
      if (cen[BASE-2]) cpuHi <= ~(cpuHi & ~contend);
      contendQ <= bus.vidCn & cacc & cpuHi & ioT & mrT & (spdAct == SPD_35);
    end
  end

  assign bus.cep     = cep;
  assign bus.cen     = cen;
  assign bus.cpuCep  = cpuCep;
  assign bus.cpuCen  = cpuCen;
  assign bus.contend = contend;
  assign bus.spdAct  = spdAct;

endmodule

// File: tb/tb_cpu_clken.sv
// tb/tb_cpu_clken.sv - self-checking bench for cpu_clken
module tb_cpu_clken;
  localparam int DIVW = 4;
  localparam int BASE = 3;
  localparam int NSPD = 3;
  localparam int PER  = 1 << DIVW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  cpu_clken_if #(.DIVW(DIVW)) bus ();

  cpu_clken #(.DIVW(DIVW), .BASE(BASE), .NSPD(NSPD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: time since reset gives the phase, turbo level from speed arithmetic
  int              m_t;
  logic [1:0]      m_spd;
  logic [DIVW-1:0] m_cep, m_cen;
  logic            m_cont, m_hi, m_ccd, m_io, m_mr;
  logic            r_contOut, r_cepOut, r_cacc, r_next;
  int              r_phase;

  function automatic logic exp_contend();
    return m_cont && (m_spd == 2'd0);
  endfunction

  function automatic logic exp_cpu_cep();
    return m_cep[BASE - int'(m_spd) - 1] && !exp_contend();
  endfunction

  function automatic logic exp_cpu_cen();
    return m_cen[BASE - int'(m_spd) - 1] && (!exp_contend() || m_ccd);
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_t = 0; m_spd = 2'd0; m_cep = '0; m_cen = '0;
      m_cont = 1'b0; m_hi = 1'b1; m_ccd = 1'b1; m_io = 1'b1; m_mr = 1'b1;
    end else begin
      r_phase   = m_t % PER;
      r_contOut = exp_contend();
      r_cepOut  = exp_cpu_cep();
      r_cacc    = (!bus.mreq && bus.a[15:14] == 2'b01)
                || (bus.model && !bus.mreq && bus.a[15:14] == 2'b11 && bus.pageCn)
                || (!bus.iorq && (bus.a[0] == 1'b0 || bus.a[15:14] == 2'b01));
      r_next    = bus.vidCn && r_cacc && m_hi && m_io && m_mr && (m_spd == 2'd0);
      if (m_cep[0]) m_ccd = !r_contOut;
      if (r_cepOut) begin
        m_io = bus.iorq || bus.a[0];
        m_mr = bus.mreq;
      end
      if (m_cen[BASE-2]) m_hi = !(m_hi && !r_contOut);
      if (r_phase == 0) m_spd = (int'(bus.speed) >= NSPD) ? 2'(NSPD - 1) : bus.speed;
      for (int k = 1; k <= DIVW; k++) begin
        m_cen[k-1] = (r_phase % (1 << k)) == 0;
        m_cep[k-1] = (r_phase % (1 << k)) == (1 << (k - 1));
      end
      m_cont = r_next;
      m_t++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_in(input logic [1:0] spd, input logic mdl, input logic pg, input logic vid,
                        input logic mq, input logic iq, input logic [15:0] adr);
    bus.speed = spd; bus.model = mdl; bus.pageCn = pg; bus.vidCn = vid;
    bus.mreq = mq; bus.iorq = iq; bus.a = adr;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  speed;
    logic        model, pageCn, vidCn, mreq, iorq;
    logic [15:0] a;
    logic        expCont;
    logic [1:0]  expSpd;
    int          expCepCnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n0, n1, n2, p0, p1, viol, cnt;
    logic [DIVW-1:0] pcep, pcen;

    //            name          spd  mdl pg vid mq iq  a         cont spd cpuCep/32
    vecs[0]  = '{"mem4000_48",  2'd0, 0, 0, 1, 0, 1, 16'h4000, 1'b1, 2'd0, 0};
    vecs[1]  = '{"mem4000_s1",  2'd1, 0, 0, 1, 0, 1, 16'h4000, 1'b0, 2'd1, 8};
    vecs[2]  = '{"c000_128_pg", 2'd0, 1, 1, 1, 0, 1, 16'hC000, 1'b1, 2'd0, 0};
    vecs[3]  = '{"c000_128_np", 2'd0, 1, 0, 1, 0, 1, 16'hC000, 1'b0, 2'd0, 4};
    vecs[4]  = '{"c000_48_pg",  2'd0, 0, 1, 1, 0, 1, 16'hC000, 1'b0, 2'd0, 4};
    vecs[5]  = '{"c000_48_np",  2'd0, 0, 0, 1, 0, 1, 16'hC000, 1'b0, 2'd0, 4};
    vecs[6]  = '{"io_even",     2'd0, 0, 0, 1, 1, 0, 16'h00FE, 1'b1, 2'd0, 0};
    vecs[7]  = '{"io_odd",      2'd0, 0, 0, 1, 1, 0, 16'h00FF, 1'b0, 2'd0, 4};
    vecs[8]  = '{"io_40ff",     2'd0, 0, 0, 1, 1, 0, 16'h40FF, 1'b1, 2'd0, 0};
    vecs[9]  = '{"no_video",    2'd0, 0, 0, 0, 0, 1, 16'h4000, 1'b0, 2'd0, 4};
    vecs[10] = '{"spd_clamp",   2'd3, 0, 0, 1, 0, 1, 16'h4000, 1'b0, 2'd2, 16};
    vecs[11] = '{"mem8000",     2'd0, 0, 0, 1, 0, 1, 16'h8000, 1'b0, 2'd0, 4};

    set_in(2'd0, 0, 0, 0, 1, 1, 16'h0000);
    reset = 1'b0;
    step();

    // Reset state
    check("rst_cep", 32'(bus.cep), 32'h0);
    check("rst_cen", 32'(bus.cen), 32'h0);
    check("rst_contend", 32'(bus.contend), 32'h0);
    check("rst_spdAct", 32'(bus.spdAct), 32'h0);

    // Divider pulse pattern over 32 clocks after release
    do_reset();
    n0 = 0; n1 = 0; n2 = 0; p0 = -1; p1 = -1; viol = 0; pcep = '0; pcen = '0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (bus.cen[3]) begin if (n0 == 1) p0 = i - p0; else p0 = i; n0++; end
      if (bus.cep[3]) begin if (n1 == 1) p1 = i - p1; else p1 = i; n1++; end
      if (bus.cen[0]) n2++;
      viol += $countones(bus.cep & pcep) + $countones(bus.cen & pcen);
      pcep = bus.cep; pcen = bus.cen;
    end
    check("div_cen3_count", 32'(n0), 32'd2);
    check("div_cen3_gap", 32'(p0), 32'd16);
    check("div_cep3_count", 32'(n1), 32'd2);
    check("div_cep3_gap", 32'(p1), 32'd16);
    check("div_cen0_count", 32'(n2), 32'd16);
    check("div_width", 32'(viol), 32'd0);

    // Speed 2 requested at cnt=5 waits for the wrap
    do_reset();
    for (int i = 0; i < 5; i++) step();
    bus.speed = 2'd2;
    viol = 0;
    for (int i = 6; i <= 16; i++) begin
      step();
      if (bus.spdAct != 2'd0) viol++;
    end
    check("spd_hold", 32'(viol), 32'd0);
    step();
    check("spd_switch", 32'(bus.spdAct), 32'd2);
    check("spd_first_cen", 32'(bus.cpuCen), 32'd1);
    viol = 0; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.cpuCep !== bus.cep[0] || bus.cpuCen !== bus.cen[0]) viol++;
      if (bus.cpuCep) cnt++;
      step();
    end
    check("spd_follow", 32'(viol), 32'd0);
    check("spd_cep_count", 32'(cnt), 32'd8);

    // Table of access patterns
    for (int v = 0; v < 12; v++) begin
      set_in(vecs[v].speed, vecs[v].model, vecs[v].pageCn, vecs[v].vidCn,
             vecs[v].mreq, vecs[v].iorq, vecs[v].a);
      do_reset();
      for (int i = 0; i < 20; i++) step();
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
        if (bus.cpuCep) cnt++;
        step();
      end
      check({vecs[v].name, "_contend"}, 32'(bus.contend), 32'(vecs[v].expCont));
      check({vecs[v].name, "_spd"}, 32'(bus.spdAct), 32'(vecs[v].expSpd));
      check({vecs[v].name, "_cepcnt"}, 32'(cnt), 32'(vecs[v].expCepCnt));
    end

    // vidCn falling releases the stretch at the next CPU pulse
    set_in(2'd0, 0, 0, 1, 0, 1, 16'h4000);
    do_reset();
    for (int i = 0; i < 20; i++) step();
    check("vid_stretch", 32'(bus.contend), 32'd1);
    bus.vidCn = 1'b0;
    step();
    check("vid_release", 32'(bus.contend), 32'd0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cpuCep) n0++;
      if (bus.cpuCen) n1++;
      if (i < 7) step();
    end
    check("vid_cep_resume", 32'(n0), 32'd1);
    check("vid_cen_resume", 32'(n1), 32'd1);

    // One-clock reset in the middle of contention
    bus.vidCn = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) step();
    check("mid_contend_pre", 32'(bus.contend), 32'd1);
    reset = 1'b0;
    step();
    check("mid_rst_contend", 32'(bus.contend), 32'd0);
    check("mid_rst_spd", 32'(bus.spdAct), 32'd0);
    check("mid_rst_pulses", 32'({bus.cep, bus.cen, bus.cpuCep, bus.cpuCen}), 32'd0);
    reset = 1'b1;
    step();
    check("mid_rst_first_cen", 32'(bus.cen), 32'(PER - 1));
    check("mid_rst_first_cep", 32'(bus.cep), 32'd0);

    // Randomised run against the reference model
    set_in(2'd0, 0, 0, 0, 1, 1, 16'h0000);
    for (int i = 0; i < 2000; i++) begin
      check("rand_outputs",
            32'({bus.cep, bus.cen, bus.cpuCep, bus.cpuCen, bus.contend, bus.spdAct}),
            32'({m_cep, m_cen, exp_cpu_cep(), exp_cpu_cen(), exp_contend(), m_spd}));
      reset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 31) == 0) bus.speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bus.vidCn = ~bus.vidCn;
      if ($urandom_range(0, 63) == 0) bus.model = ~bus.model;
      bus.pageCn = ($urandom_range(0, 3) != 0);
      bus.mreq   = ($urandom_range(0, 2) == 0);
      bus.iorq   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       bus.a = 16'h4000 | 16'($urandom_range(0, 16383));
        1:       bus.a = 16'hC000 | 16'($urandom_range(0, 16383));
        2:       bus.a = 16'h8000 | 16'($urandom_range(0, 16383));
        3:       bus.a = 16'($urandom_range(0, 16383));
        default: bus.a = 16'($urandom);
      endcase
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_clken.md
Name: cpu_clken

Overview:
Parametrised clock-enable and CPU contention generator that replaces the fixed 14/7/3.5/1.75 MHz enable decode and ULA contention logic in the Spectrum top level. It derives one-cycle p/n enable pulses for DIVW power-of-two divisions of the master clock. It drives the CPU enables at a selectable turbo speed, with glitch-free speed switching. It applies 48K or 128K memory/IO contention, only at the base speed.

Parameters:
- DIVW, 4, number of division levels. Level k (1..DIVW) runs at clock/2^k.
- BASE, 3, level used for CPU speed 0 (3.5 MHz at a 28 MHz master clock).
- NSPD, 3, number of turbo speeds. Speed s uses level BASE-s. Requires NSPD <= BASE.

Ports:
- clock  in  1  master clock; all logic on posedge
- reset  in  1  synchronous, active-low
- speed  in  2  requested turbo speed; values >= NSPD are clamped to NSPD-1
- model  in  1  0 = 48K contention, 1 = 128K contention
- pageCn in  1  upper 16K bank is a contended page (128K only)
- vidCn  in  1  video fetch window active, from video
- mreq   in  1  CPU mreq, active-low
- iorq   in  1  CPU iorq, active-low
- a      in  16 CPU address
- cep    out DIVW  level-k positive-phase pulse on bit k-1
- cen    out DIVW  level-k negative-phase pulse on bit k-1
- cpuCep out 1  CPU positive enable
- cpuCen out 1  CPU negative enable
- contend out 1 contention currently stretching the CPU clock
- spdAct out 2  speed currently in effect

Behaviour:
- Reset state:
  - While reset=0: counter cnt[DIVW-1:0] = 0, spdAct = 0, all pulses 0, contend = 0.
  - Internal registers cpuHi (modelled CPU clock level) = 1, ccd = 1, ioT = 1, mrT = 1.
- Divider:
  - cnt increments every clock and wraps from 2^DIVW-1 to 0.
  - Level k: cen[k-1] = (cnt[k-1:0] == 0); cep[k-1] = (cnt[k-1:0] == 2^(k-1)).
  - Both outputs are registered, so they are 1 clock late relative to the cnt value. Each pulse is exactly 1 clock wide.
- Speed switching:
  - spdAct loads the clamped speed only when cnt == 0, where all level boundaries coincide. This guarantees no partial CPU half-cycle.
  - A request that changes and then reverts before cnt == 0 has no effect.
- CPU enables:
  - The level L = BASE - spdAct pulses are gated as follows.
  - cpuCep = cep[L-1] & ~contend.
  - cpuCen = cen[L-1] & (~contend | ccd).
- ccd:
  - ccd samples ~contend on every cep[0].
- Contended access (cacc):
  - mreq=0 and a[15:14] = 01; or
  - model=1, mreq=0, a[15:14] = 11 and pageCn=1; or
  - iorq=0 and a[0]=0; or
  - iorq=0 and a[15:14] = 01.
- ioT and mrT:
  - Both sample on each cpuCep: ioT <= (iorq | a[0]); mrT <= mreq.
- Contend:
  - contend = vidCn & cacc & cpuHi & ioT & mrT & (spdAct == 0). This value is registered.
  - At spdAct != 0, contend is forced to 0.
- cpuHi:
  - On cen[BASE-2]: cpuHi <= ~(cpuHi & ~contend). This matches the existing half-period toggle.
- Simultaneous events:
  - A speed change at cnt==0 coincident with contention: the new speed applies and contend drops on the next clock.
  - vidCn falling mid-stretch releases the stretch at the next CPU pulse.
- Reset mid-operation:
  - All state returns to its reset values on the next clock.
  - Pulses resume with the first cen at cnt==0 after reset deasserts. That pulse is visible on the outputs 1 clock later.

Decomposition:
- Package cpu_clken_pkg:
  - speed encodings SPD_35, SPD_7, SPD_14;
  - MODEL_48, MODEL_128;
  - helper function lvl(speed).
- Sub-module ce_divider (counter plus p/n pulse decode, parametrised by DIVW), instantiated once.

Test Plan:
- Reset released, DIVW=4: over 32 clocks cen[3] and cep[3] each pulse twice, 16 apart. cen[0] pulses 16 times. All pulses are 1 clock wide.
- speed=2 applied at cnt=5: spdAct stays 0 until cnt wraps to 0, then becomes 2. cpuCep then follows cep[0] with no truncated half-cycle.
- speed=0, model=0, vidCn=1, mreq=0, a=16'h4000: contend=1 and cpuCep is suppressed until vidCn=0. No cpuCen is lost (ccd path).
- Same access with speed=1: contend=0 throughout and cpuCep follows cep[1].
- model=1, a=16'hC000, mreq=0: pageCn=1 stretches the clock; pageCn=0 gives no stretch. With model=0, neither case stretches.
- reset=0 asserted for 1 clock mid-contention: next clock has cnt=0, contend=0, spdAct=0 and all pulses 0.
